// File: rtl/mod_multiosc.sv
// Multi-channel oscillator: per-channel phase accumulators sharing one quarter-wave sine LUT.
// Each trigger walks every channel once and streams one 18.14 sample per channel.
//
// state   | meaning
// S_IDLE  | waiting for i_trigger
// S_RUN   | one slot per cycle, slot c reads and steps channel c
// S_DRAIN | two cycles letting the last slot leave the pipeline
module mod_multiosc #(
    parameter int NUM_CH      = 4,
    parameter int PHASE_W     = 32,
    parameter int FREQ_W      = 16,
    parameter int LUT_AW      = 8,
    parameter int SAMPLE_RATE = 48000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_trigger,
    input  logic              i_wr_en,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [FREQ_W-1:0] i_wr_freq,
    input  logic [1:0]        i_wr_mode,
    input  logic              i_wr_enable,
    input  logic              i_wr_phase_rst,
    output logic [31:0]       o_sample,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_valid,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam longint unsigned INC_SCALE =
        ((64'd1 << PHASE_W) + 64'(SAMPLE_RATE / 2)) / 64'(SAMPLE_RATE);
    localparam int  LUT_N   = 2 ** LUT_AW;
    localparam int  TOP_W   = (LUT_AW + 2 > 16) ? LUT_AW + 2 : 16;
    localparam real HALF_PI = 1.5707963267948966;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    function automatic logic [PHASE_W-1:0] phase_inc(input logic [FREQ_W-1:0] f);
        logic [63:0] prod;
        prod = 64'(f) * INC_SCALE;
        return prod[PHASE_W-1:0];
    endfunction

    logic [15:0] lut_rom [0:LUT_N];
    for (genvar n = 0; n <= LUT_N; n++) begin : g_lut
        localparam int VAL = $rtoi(16384.0 * $sin(HALF_PI * n / LUT_N) + 0.5);
        assign lut_rom[n] = 16'(VAL);
    end

    logic [PHASE_W-1:0] phase  [NUM_CH];
    logic [FREQ_W-1:0]  freq   [NUM_CH];
    logic [1:0]         mode   [NUM_CH];
    logic               enable [NUM_CH];

    state_t            state, state_next;
    logic [CH_W-1:0]   slot, slot_next;
    logic              drain, drain_next;
    logic              slot_active, slot_last;

    logic              s1_valid, s1_last, s1_en;
    logic [CH_W-1:0]   s1_ch;
    logic [1:0]        s1_mode;
    logic [TOP_W-1:0]  s1_top;

    logic              s2_valid, s2_last, s2_en, s2_neg;
    logic [CH_W-1:0]   s2_ch;
    logic [1:0]        s2_mode;
    logic [15:0]       lut_q;
    logic signed [16:0] s2_wave;

    logic [LUT_AW-1:0] lut_i;
    logic [LUT_AW:0]   lut_addr;
    logic [14:0]       saw_u, tri_u;
    logic signed [16:0] wave_c;
    logic [31:0]       sample_c;

    assign slot_last = (slot == CH_W'(NUM_CH - 1));

    always_comb begin
        state_next  = state;
        slot_next   = slot;
        drain_next  = drain;
        slot_active = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_trigger) begin
                    state_next = S_RUN;
                    slot_next  = '0;
                end
            end
            S_RUN: begin
                slot_active = 1'b1;
                if (slot_last) begin
                    state_next = S_DRAIN;
                    drain_next = 1'b0;
                end else begin
                    slot_next = slot + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain) state_next = S_IDLE;
                else       drain_next = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            slot      <= '0;
            drain     <= 1'b0;
            o_overrun <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                phase[c]  <= '0;
                freq[c]   <= '0;
                mode[c]   <= '0;
                enable[c] <= 1'b0;
            end
        end else begin
            state <= state_next;
            slot  <= slot_next;
            drain <= drain_next;
            if (i_trigger && state != S_IDLE) o_overrun <= 1'b1;
            // A config write to a channel takes precedence over its phase step.
            for (int c = 0; c < NUM_CH; c++) begin
                if (i_wr_en && i_wr_ch == CH_W'(c)) begin
                    freq[c]   <= i_wr_freq;
                    mode[c]   <= i_wr_mode;
                    enable[c] <= i_wr_enable;
                    if (i_wr_phase_rst) phase[c] <= '0;
                end else if (slot_active && slot == CH_W'(c) && enable[c]) begin
                    phase[c] <= phase[c] + phase_inc(freq[c]);
                end
            end
        end
    end

    always_comb begin
        lut_i    = s1_top[TOP_W-3 -: LUT_AW];
        lut_addr = s1_top[TOP_W-2] ? ((LUT_AW+1)'(LUT_N) - {1'b0, lut_i}) : {1'b0, lut_i};
        saw_u    = s1_top[TOP_W-1 -: 15];
        tri_u    = s1_top[TOP_W-2 -: 15];
        wave_c   = '0;
        case (s1_mode)
            2'd1: wave_c = s1_top[TOP_W-1] ? -17'sd16384 : 17'sd16384;
            2'd2: wave_c = $signed({2'b00, saw_u}) - 17'sd16384;
            2'd3: wave_c = s1_top[TOP_W-1] ? (17'sd16383 - $signed({2'b00, tri_u}))
                                           : ($signed({2'b00, tri_u}) - 17'sd16384);
            default: wave_c = '0;
        endcase
    end

    always_comb begin
        sample_c = '0;
        if (s2_en) begin
            if (s2_mode == 2'd0) sample_c = s2_neg ? -(32'(lut_q)) : 32'(lut_q);
            else                 sample_c = {{15{s2_wave[16]}}, s2_wave};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0; s1_last <= 1'b0; s1_en <= 1'b0;
            s1_ch    <= '0;   s1_mode <= '0;   s1_top <= '0;
            s2_valid <= 1'b0; s2_last <= 1'b0; s2_en <= 1'b0; s2_neg <= 1'b0;
            s2_ch    <= '0;   s2_mode <= '0;   lut_q <= '0;   s2_wave <= '0;
            o_sample <= '0;   o_ch    <= '0;   o_valid <= 1'b0; o_done <= 1'b0;
        end else begin
            s1_valid <= slot_active;
            s1_last  <= slot_active && slot_last;
            s1_ch    <= slot;
            s1_en    <= enable[slot];
            s1_mode  <= mode[slot];
            s1_top   <= phase[slot][PHASE_W-1 -: TOP_W];

            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_ch    <= s1_ch;
            s2_en    <= s1_en;
            s2_mode  <= s1_mode;
            s2_neg   <= s1_top[TOP_W-1];
            lut_q    <= lut_rom[lut_addr];
            s2_wave  <= wave_c;

            o_valid  <= s2_valid;
            o_done   <= s2_valid && s2_last;
            o_ch     <= s2_valid ? s2_ch : '0;
            o_sample <= s2_valid ? sample_c : '0;
        end
    end

    assign o_busy = (state != S_IDLE) || o_done;

endmodule
